riscv_dmem_stall_bridge: RTL and testbench
==========================================

RISCV_DMEM_STALL_BRIDGE -- requirements
Module: riscv_dmem_stall_bridge

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be 32 or 64; NB = XLEN/8 byte lanes.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum cycles spent in REQ+WAIT before abort; range 1..65535.
REQ-003 i_clk  in  1  single clock, all state on rising edge.
REQ-004 i_rstn  in  1  asynchronous, active-low reset.
REQ-005 i_dsb_req  in  1  MEM-stage access request, held stable while o_dsb_stall=1.
REQ-006 i_dsb_wr_en  in  1  1=store, 0=load.
REQ-007 i_dsb_func3  in  3  RISC-V load/store funct3.
REQ-008 i_dsb_addr  in  XLEN  byte address.
REQ-009 i_dsb_wr_data  in  XLEN  store data, LSB-aligned.
REQ-010 o_dsb_stall  out  1  freeze pipeline.
REQ-011 o_dsb_rd_valid  out  1  load result valid, one-cycle pulse.
REQ-012 o_dsb_rd_data  out  XLEN  extended load result.
REQ-013 o_dsb_exc  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-014 o_dsb_mem_req  out  1  memory request.
REQ-015 o_dsb_mem_wr_en  out  1  memory write.
REQ-016 o_dsb_mem_addr  out  XLEN  lane-aligned address (low log2(NB) bits zero).
REQ-017 o_dsb_mem_byte_sel  out  NB  byte enables.
REQ-018 o_dsb_mem_wr_data  out  XLEN  lane-positioned store data.
REQ-019 i_dsb_mem_gnt  in  1  memory accepted request this cycle.
REQ-020 i_dsb_mem_rvalid  in  1  read data valid.
REQ-021 i_dsb_mem_rd_data  in  XLEN  full-lane read data.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, DONE; single outstanding access.
REQ-023 IDLE: i_dsb_req=1 with legal, aligned access SHALL capture addr/func3/wr_en/wr_data and go to REQ; otherwise stay IDLE.
REQ-024 Illegal funct3: loads 011 (XLEN=32), 110 (XLEN=32), 111; stores >=100, or 011 with XLEN=32 -> o_dsb_exc=10 combinationally in IDLE, no memory access, no stall.
REQ-025 Misaligned (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0) -> o_dsb_exc=01 combinationally in IDLE, no memory access, no stall; illegal takes priority over misaligned.
REQ-026 REQ: o_dsb_mem_req=1 with registered fields; on i_dsb_mem_gnt store -> DONE, load -> WAIT.
REQ-027 WAIT: on i_dsb_mem_rvalid capture extended data -> DONE; i_dsb_mem_rvalid outside WAIT SHALL be ignored.
REQ-028 DONE: one cycle, o_dsb_rd_valid=1 for loads only, then IDLE unconditionally; i_dsb_req in DONE belongs to the completing access.
REQ-029 o_dsb_stall = (IDLE & i_dsb_req & legal & aligned) | REQ | WAIT.
REQ-030 Timeout counter SHALL clear on IDLE->REQ, increment each REQ/WAIT cycle; at TIMEOUT_CYCLES -> DONE with o_dsb_exc=11, o_dsb_rd_data=0, o_dsb_rd_valid=0, o_dsb_mem_req dropped.
REQ-031 Byte select: SB 1<<off, SH 3<<off, SW 4'hF<<off, SD all ones; off = addr[log2(NB)-1:0].
REQ-032 Store data SHALL be shifted left by 8*off; unselected lanes don't-care but driven 0.
REQ-033 Load: shift read data right by 8*off, sign-extend LB/LH/LW(XLEN=64), zero-extend LBU/LHU/LWU; LW on XLEN=32 and LD pass through.
REQ-034 o_dsb_rd_data SHALL hold last value until next load completion or timeout.

Reset
REQ-035 i_rstn=0 SHALL immediately force IDLE, timeout counter 0, o_dsb_mem_req/wr_en/rd_valid/stall 0, o_dsb_exc 00, o_dsb_rd_data/mem_addr/mem_byte_sel/mem_wr_data 0, including mid-access; late gnt/rvalid after reset ignored.

Verification
REQ-036 XLEN=32, LB addr 0x103, gnt in 1st REQ cycle, rvalid 2 cycles later data 0x80FF_0000 -> byte_sel 1000, rd_data 0xFFFF_FF80, stall 4 cycles, rd_valid one pulse.
REQ-037 XLEN=32, SH addr 0x202 data 0x0000_ABCD, gnt after 3 cycles -> mem_addr 0x200, byte_sel 1100, wr_data 0xABCD_0000, no rd_valid.
REQ-038 XLEN=64, LWU addr 0x4 read 0x8000_0001_xxxx_xxxx -> rd_data 0x0000_0000_8000_0001; LW same -> 0xFFFF_FFFF_8000_0001.
REQ-039 SW addr 0x6 -> exc 01, no mem_req, no stall; XLEN=32 LD -> exc 10.
REQ-040 TIMEOUT_CYCLES=4, gnt never asserted -> mem_req 4 cycles, DONE exc 11, rd_data 0; then i_rstn pulse during WAIT -> all outputs 0 same cycle.

Source files
------------

// File: rtl/riscv_dmem_stall_bridge.sv
// Data-memory bridge between the MEM pipeline stage and a req/gnt/rvalid memory port.
// One outstanding access; the pipeline is stalled until the access completes, faults or times out.
module riscv_dmem_stall_bridge #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_dsb_req,
    input  logic                 i_dsb_wr_en,
    input  logic [2:0]           i_dsb_func3,
    input  logic [XLEN-1:0]      i_dsb_addr,
    input  logic [XLEN-1:0]      i_dsb_wr_data,
    output logic                 o_dsb_stall,
    output logic                 o_dsb_rd_valid,
    output logic [XLEN-1:0]      o_dsb_rd_data,
    output logic [1:0]           o_dsb_exc,
    output logic                 o_dsb_mem_req,
    output logic                 o_dsb_mem_wr_en,
    output logic [XLEN-1:0]      o_dsb_mem_addr,
    output logic [XLEN/8-1:0]    o_dsb_mem_byte_sel,
    output logic [XLEN-1:0]      o_dsb_mem_wr_data,
    input  logic                 i_dsb_mem_gnt,
    input  logic                 i_dsb_mem_rvalid,
    input  logic [XLEN-1:0]      i_dsb_mem_rd_data
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic            wr_en_q;
    logic [2:0]      func3_q;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [NB-1:0]   byte_sel_q;
    logic [XLEN-1:0] wr_data_q;

    logic            illegal;
    logic            misaligned;
    logic            accept;
    logic [OFFW-1:0] req_off;
    logic [NB-1:0]   byte_sel_c;
    logic [XLEN-1:0] wr_data_c;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] rd_ext;

    assign req_off = i_dsb_addr[OFFW-1:0];

    always_comb begin
        illegal = 1'b0;
        if (i_dsb_wr_en) begin
            illegal = i_dsb_func3[2] || (i_dsb_func3 == 3'b011 && XLEN == 32);
        end else begin
            illegal = (i_dsb_func3 == 3'b111) ||
                      ((i_dsb_func3 == 3'b011 || i_dsb_func3 == 3'b110) && XLEN == 32);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (i_dsb_func3[1:0])
            2'b01:   misaligned = i_dsb_addr[0];
            2'b10:   misaligned = |i_dsb_addr[1:0];
            2'b11:   misaligned = |i_dsb_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign accept = (state_q == S_IDLE) && i_dsb_req && !illegal && !misaligned;

    // Store data is truncated to the access size before lane positioning so unused lanes drive zero.
    always_comb begin
        byte_sel_c = '0;
        wr_data_c  = '0;
        case (i_dsb_func3[1:0])
            2'b00: begin
                byte_sel_c = NB'(1) << req_off;
                wr_data_c  = XLEN'(i_dsb_wr_data[7:0]);
            end
            2'b01: begin
                byte_sel_c = NB'(3) << req_off;
                wr_data_c  = XLEN'(i_dsb_wr_data[15:0]);
            end
            2'b10: begin
                byte_sel_c = NB'(4'hF) << req_off;
                wr_data_c  = XLEN'(i_dsb_wr_data[31:0]);
            end
            default: begin
                byte_sel_c = '1;
                wr_data_c  = i_dsb_wr_data;
            end
        endcase
        wr_data_c = wr_data_c << {req_off, 3'b000};
    end

    assign rd_shift = i_dsb_mem_rd_data >> {off_q, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (func3_q)
            3'b000:  rd_ext = XLEN'($signed(rd_shift[7:0]));
            3'b001:  rd_ext = XLEN'($signed(rd_shift[15:0]));
            3'b010:  rd_ext = XLEN'($signed(rd_shift[31:0]));
            3'b100:  rd_ext = XLEN'(rd_shift[7:0]);
            3'b101:  rd_ext = XLEN'(rd_shift[15:0]);
            3'b110:  rd_ext = XLEN'(rd_shift[31:0]);
            default: rd_ext = rd_shift;
        endcase
    end

    // The counter keeps running across REQ->WAIT, so the limit check uses >= rather than ==.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_REQ;
                    tmo_cnt_d = '0;
                    tmo_d     = 1'b0;
                end
            end
            S_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (i_dsb_mem_gnt) begin
                    state_d = wr_en_q ? S_DONE : S_WAIT;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    state_d   = S_DONE;
                    tmo_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (i_dsb_mem_rvalid) begin
                    state_d   = S_DONE;
                    rd_data_d = rd_ext;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    state_d   = S_DONE;
                    tmo_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_en_q    <= 1'b0;
            func3_q    <= '0;
            off_q      <= '0;
            mem_addr_q <= '0;
            byte_sel_q <= '0;
            wr_data_q  <= '0;
        end else if (accept) begin
            wr_en_q    <= i_dsb_wr_en;
            func3_q    <= i_dsb_func3;
            off_q      <= req_off;
            mem_addr_q <= i_dsb_addr & ~XLEN'(NB - 1);
            byte_sel_q <= byte_sel_c;
            wr_data_q  <= wr_data_c;
        end
    end

    // Combinational IDLE outputs are gated by reset so an asserted request cannot leak through.
    assign o_dsb_stall = i_rstn && (accept || state_q == S_REQ || state_q == S_WAIT);

    always_comb begin
        o_dsb_exc = 2'b00;
        if (i_rstn) begin
            if (state_q == S_IDLE && i_dsb_req) begin
                if (illegal)         o_dsb_exc = 2'b10;
                else if (misaligned) o_dsb_exc = 2'b01;
            end else if (state_q == S_DONE && tmo_q) begin
                o_dsb_exc = 2'b11;
            end
        end
    end

    assign o_dsb_rd_valid     = (state_q == S_DONE) && !wr_en_q && !tmo_q;
    assign o_dsb_rd_data      = rd_data_q;
    assign o_dsb_mem_req      = (state_q == S_REQ);
    assign o_dsb_mem_wr_en    = (state_q == S_REQ) && wr_en_q;
    assign o_dsb_mem_addr     = mem_addr_q;
    assign o_dsb_mem_byte_sel = byte_sel_q;
    assign o_dsb_mem_wr_data  = wr_data_q;

endmodule

// File: tb/tb_riscv_dmem_stall_bridge.sv
// Directed bench for riscv_dmem_stall_bridge: a 32-bit instance (short timeout) and a 64-bit instance.
module tb_riscv_dmem_stall_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, sel64, req, wr, gnt, rvalid;
    logic [2:0]  f3;
    logic [63:0] addr, wdata, rdata;

    logic        s32_stall, s32_rd_valid, s32_mem_req, s32_mem_wr_en;
    logic [31:0] s32_rd_data, s32_mem_addr, s32_mem_wdata;
    logic [1:0]  s32_exc;
    logic [3:0]  s32_bsel;

    logic        s64_stall, s64_rd_valid, s64_mem_req, s64_mem_wr_en;
    logic [63:0] s64_rd_data, s64_mem_addr, s64_mem_wdata;
    logic [1:0]  s64_exc;
    logic [7:0]  s64_bsel;

    logic        v_stall, v_rd_valid, v_mem_req, v_mem_wr_en;
    logic [63:0] v_rd_data, v_mem_addr, v_mem_wdata;
    logic [1:0]  v_exc;
    logic [7:0]  v_bsel;

    riscv_dmem_stall_bridge #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (
        .i_clk(clk), .i_rstn(rstn),
        .i_dsb_req(req && !sel64), .i_dsb_wr_en(wr), .i_dsb_func3(f3),
        .i_dsb_addr(addr[31:0]), .i_dsb_wr_data(wdata[31:0]),
        .o_dsb_stall(s32_stall), .o_dsb_rd_valid(s32_rd_valid), .o_dsb_rd_data(s32_rd_data),
        .o_dsb_exc(s32_exc), .o_dsb_mem_req(s32_mem_req), .o_dsb_mem_wr_en(s32_mem_wr_en),
        .o_dsb_mem_addr(s32_mem_addr), .o_dsb_mem_byte_sel(s32_bsel), .o_dsb_mem_wr_data(s32_mem_wdata),
        .i_dsb_mem_gnt(gnt), .i_dsb_mem_rvalid(rvalid), .i_dsb_mem_rd_data(rdata[31:0])
    );

    riscv_dmem_stall_bridge #(.XLEN(64), .TIMEOUT_CYCLES(255)) dut64 (
        .i_clk(clk), .i_rstn(rstn),
        .i_dsb_req(req && sel64), .i_dsb_wr_en(wr), .i_dsb_func3(f3),
        .i_dsb_addr(addr), .i_dsb_wr_data(wdata),
        .o_dsb_stall(s64_stall), .o_dsb_rd_valid(s64_rd_valid), .o_dsb_rd_data(s64_rd_data),
        .o_dsb_exc(s64_exc), .o_dsb_mem_req(s64_mem_req), .o_dsb_mem_wr_en(s64_mem_wr_en),
        .o_dsb_mem_addr(s64_mem_addr), .o_dsb_mem_byte_sel(s64_bsel), .o_dsb_mem_wr_data(s64_mem_wdata),
        .i_dsb_mem_gnt(gnt), .i_dsb_mem_rvalid(rvalid), .i_dsb_mem_rd_data(rdata)
    );

    // Single view of whichever instance is currently addressed.
    always_comb begin
        if (sel64) begin
            v_stall = s64_stall;   v_rd_valid = s64_rd_valid;   v_mem_req = s64_mem_req;
            v_mem_wr_en = s64_mem_wr_en; v_rd_data = s64_rd_data; v_mem_addr = s64_mem_addr;
            v_mem_wdata = s64_mem_wdata; v_exc = s64_exc; v_bsel = s64_bsel;
        end else begin
            v_stall = s32_stall;   v_rd_valid = s32_rd_valid;   v_mem_req = s32_mem_req;
            v_mem_wr_en = s32_mem_wr_en; v_rd_data = 64'(s32_rd_data); v_mem_addr = 64'(s32_mem_addr);
            v_mem_wdata = 64'(s32_mem_wdata); v_exc = s32_exc; v_bsel = 8'(s32_bsel);
        end
    end

    typedef struct {
        logic        sel64;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  exc;
        logic [63:0] maddr;
        logic [7:0]  bsel;
        logic [63:0] mwdata;
        logic [63:0] rd;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d_", idx);
        @(negedge clk);
        sel64 = v.sel64; req = 1'b1; wr = v.wr; f3 = v.f3; addr = v.addr;
        wdata = v.wdata; rdata = v.rdata; gnt = 1'b0; rvalid = 1'b0;
        #1;
        chk({p, "exc"}, 64'(v_exc), 64'(v.exc));
        if (v.exc != 2'b00) begin
            chk({p, "stall_fault"}, 64'(v_stall), 64'd0);
            chk({p, "mem_req_fault"}, 64'(v_mem_req), 64'd0);
            @(negedge clk);
            #1;
            chk({p, "mem_req_fault_next"}, 64'(v_mem_req), 64'd0);
            req = 1'b0;
            return;
        end
        chk({p, "stall_idle"}, 64'(v_stall), 64'd1);
        @(negedge clk);
        #1;
        chk({p, "mem_req"}, 64'(v_mem_req), 64'd1);
        chk({p, "mem_wr_en"}, 64'(v_mem_wr_en), 64'(v.wr));
        chk({p, "mem_addr"}, v_mem_addr, v.maddr);
        chk({p, "byte_sel"}, 64'(v_bsel), 64'(v.bsel));
        chk({p, "mem_wdata"}, v_mem_wdata, v.mwdata);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #1;
        if (!v.wr) begin
            chk({p, "stall_wait"}, 64'(v_stall), 64'd1);
            rvalid = 1'b1;
            @(negedge clk);
            rvalid = 1'b0;
            #1;
        end
        chk({p, "rd_valid_done"}, 64'(v_rd_valid), 64'(!v.wr));
        chk({p, "rd_data"}, v_rd_data, v.rd);
        chk({p, "stall_done"}, 64'(v_stall), 64'd0);
        chk({p, "exc_done"}, 64'(v_exc), 64'd0);
        req = 1'b0;
        @(negedge clk);
        #1;
        chk({p, "rd_valid_after"}, 64'(v_rd_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_stall, n_valid, n_req, n_tmo;
        logic [63:0] cap;

        //              sel wr f3     addr          wdata                  rdata                   exc    maddr     bsel   mwdata                 rd
        vecs[0]  = '{1'b0, 1'b0, 3'b000, 64'h103, 64'h0,                 64'h80FF_0000,          2'b00, 64'h100, 8'h08, 64'h0,                 64'hFFFF_FF80};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 64'h202, 64'h0000_ABCD,         64'h0,                  2'b00, 64'h200, 8'h0C, 64'hABCD_0000,         64'hFFFF_FF80};
        vecs[2]  = '{1'b0, 1'b0, 3'b101, 64'h2,   64'h0,                 64'h8001_1234,          2'b00, 64'h0,   8'h0C, 64'h0,                 64'h0000_8001};
        vecs[3]  = '{1'b0, 1'b0, 3'b001, 64'h2,   64'h0,                 64'h8001_1234,          2'b00, 64'h0,   8'h0C, 64'h0,                 64'hFFFF_8001};
        vecs[4]  = '{1'b0, 1'b0, 3'b010, 64'h8,   64'h0,                 64'hDEAD_BEEF,          2'b00, 64'h8,   8'h0F, 64'h0,                 64'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 64'h11,  64'hFFFF_FF5A,         64'h0,                  2'b00, 64'h10,  8'h02, 64'h5A00,              64'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b0, 3'b100, 64'h1,   64'h0,                 64'h0000_F700,          2'b00, 64'h0,   8'h02, 64'h0,                 64'h0000_00F7};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 64'h6,   64'h0,                 64'h0,                  2'b01, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[8]  = '{1'b0, 1'b0, 3'b011, 64'h8,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[9]  = '{1'b0, 1'b0, 3'b001, 64'h1,   64'h0,                 64'h0,                  2'b01, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b011, 64'h8,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[11] = '{1'b0, 1'b0, 3'b111, 64'h3,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[12] = '{1'b0, 1'b0, 3'b110, 64'h4,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 64'h4,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b110, 64'h4,   64'h0,                 64'h8000_0001_1234_5678, 2'b00, 64'h0,  8'hF0, 64'h0,                 64'h0000_0000_8000_0001};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 64'h4,   64'h0,                 64'h8000_0001_1234_5678, 2'b00, 64'h0,  8'hF0, 64'h0,                 64'hFFFF_FFFF_8000_0001};
        vecs[16] = '{1'b1, 1'b0, 3'b011, 64'h8,   64'h0,                 64'h0123_4567_89AB_CDEF, 2'b00, 64'h8,  8'hFF, 64'h0,                 64'h0123_4567_89AB_CDEF};
        vecs[17] = '{1'b1, 1'b1, 3'b011, 64'h10,  64'h1122_3344_5566_7788, 64'h0,                2'b00, 64'h10,  8'hFF, 64'h1122_3344_5566_7788, 64'h0123_4567_89AB_CDEF};
        vecs[18] = '{1'b1, 1'b1, 3'b010, 64'h4,   64'hAAAA_BBBB_CCCC_DDDD, 64'h0,                2'b00, 64'h0,   8'hF0, 64'hCCCC_DDDD_0000_0000, 64'h0123_4567_89AB_CDEF};
        vecs[19] = '{1'b1, 1'b0, 3'b011, 64'h4,   64'h0,                 64'h0,                  2'b01, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[20] = '{1'b1, 1'b0, 3'b111, 64'h0,   64'h0,                 64'h0,                  2'b10, 64'h0,   8'h00, 64'h0,                 64'h0};
        vecs[21] = '{1'b1, 1'b0, 3'b000, 64'h7,   64'h0,                 64'h7F00_0000_0000_0000, 2'b00, 64'h0,  8'h80, 64'h0,                 64'h0000_0000_0000_007F};

        rstn = 1'b0; sel64 = 1'b0; req = 1'b0; wr = 1'b0; f3 = 3'b000;
        addr = '0; wdata = '0; rdata = '0; gnt = 1'b0; rvalid = 1'b0;
        #12;
        chk("rst_stall32", 64'(s32_stall), 64'd0);
        chk("rst_mem_req32", 64'(s32_mem_req), 64'd0);
        chk("rst_rd_data32", 64'(s32_rd_data), 64'd0);
        chk("rst_exc64", 64'(s64_exc), 64'd0);
        chk("rst_mem_addr64", s64_mem_addr, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i], i);
        end

        // LB with grant in the first REQ cycle and read data two cycles later
        @(negedge clk);
        sel64 = 1'b0; req = 1'b1; wr = 1'b0; f3 = 3'b000; addr = 64'h103;
        wdata = '0; rdata = 64'h80FF_0000;
        n_stall = 0; n_valid = 0; cap = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (v_stall) n_stall++;
            if (v_rd_valid) begin n_valid++; cap = v_rd_data; end
            gnt = (k == 1);
            rvalid = (k == 3);
            if (k >= 4) req = 1'b0;
            @(negedge clk);
        end
        gnt = 1'b0; rvalid = 1'b0;
        chk("lb_stall_cycles", 64'(n_stall), 64'd4);
        chk("lb_rd_valid_pulses", 64'(n_valid), 64'd1);
        chk("lb_rd_data", cap, 64'hFFFF_FF80);

        // SH with grant arriving after three waiting cycles
        @(negedge clk);
        req = 1'b1; wr = 1'b1; f3 = 3'b001; addr = 64'h202; wdata = 64'h0000_ABCD;
        n_req = 0; n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (v_mem_req) n_req++;
            if (v_rd_valid) n_valid++;
            if (k == 1) begin
                chk("sh_mem_addr", v_mem_addr, 64'h200);
                chk("sh_byte_sel", 64'(v_bsel), 64'h0C);
                chk("sh_wdata", v_mem_wdata, 64'hABCD_0000);
            end
            gnt = (k == 4);
            if (k >= 5) req = 1'b0;
            @(negedge clk);
        end
        gnt = 1'b0;
        chk("sh_mem_req_cycles", 64'(n_req), 64'd4);
        chk("sh_no_rd_valid", 64'(n_valid), 64'd0);
        chk("sh_rd_data_held", v_rd_data, 64'hFFFF_FF80);

        // Load with no grant: abort after the timeout budget
        @(negedge clk);
        req = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 64'h20; wdata = '0;
        n_req = 0; n_tmo = 0; n_valid = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (v_mem_req) n_req++;
            if (v_rd_valid) n_valid++;
            if (v_exc == 2'b11) begin
                n_tmo++;
                chk("tmo_rd_data", v_rd_data, 64'd0);
                chk("tmo_stall", 64'(v_stall), 64'd0);
                req = 1'b0;
            end
            @(negedge clk);
        end
        chk("tmo_mem_req_cycles", 64'(n_req), 64'd4);
        chk("tmo_exc_cycles", 64'(n_tmo), 64'd1);
        chk("tmo_no_rd_valid", 64'(n_valid), 64'd0);

        run_txn(vecs[4], 100);

        // Reset asserted while waiting for read data
        @(negedge clk);
        req = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 64'h44; rdata = 64'h1234_5678;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #1;
        chk("rst_wait_stall_before", 64'(v_stall), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rstw_stall", 64'(v_stall), 64'd0);
        chk("rstw_mem_req", 64'(v_mem_req), 64'd0);
        chk("rstw_mem_wr_en", 64'(v_mem_wr_en), 64'd0);
        chk("rstw_rd_valid", 64'(v_rd_valid), 64'd0);
        chk("rstw_exc", 64'(v_exc), 64'd0);
        chk("rstw_rd_data", v_rd_data, 64'd0);
        chk("rstw_mem_addr", v_mem_addr, 64'd0);
        chk("rstw_byte_sel", 64'(v_bsel), 64'd0);
        chk("rstw_mem_wdata", v_mem_wdata, 64'd0);
        @(negedge clk);
        req = 1'b0; rstn = 1'b1; gnt = 1'b1; rvalid = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b0;
        #1;
        chk("late_rd_valid", 64'(v_rd_valid), 64'd0);
        chk("late_rd_data", v_rd_data, 64'd0);
        chk("late_stall", 64'(v_stall), 64'd0);
        chk("late_mem_req", 64'(v_mem_req), 64'd0);
        @(negedge clk);
        #1;
        chk("late_rd_valid_next", 64'(v_rd_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
